// File: rtl/ad9361_capture_pkg.sv
// Shared types and widths for the AD9361 capture controller.
package ad9361_capture_pkg;

  localparam int DATA_W    = 128;
  localparam int OVF_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_t;

endpackage

// File: rtl/axis_reg_stage.sv
// Single-entry registered AXI-Stream stage (valid/ready/data/last).
import ad9361_capture_pkg::*;

module axis_reg_stage #(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  assign in_ready = ~out_valid | out_ready;

  // holding register; payload is frozen while stalled downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ad9361_capture_ctrl.sv
// Burst capture controller between the AD9361 serializer and a DMA stream.
// Optional AD9361_CAPTURE_OVF_CNT_EN adds a saturating dropped-beat counter.
import ad9361_capture_pkg::*;

module ad9361_capture_ctrl #(
  parameter int AXIS_BURST_LENGTH = 512,
  parameter int BURST_CNT_WIDTH   = 16
) (
  input  logic                       axis_clk,
  input  logic                       axis_rst,
  input  logic                       ctrl_start,
  input  logic                       ctrl_abort,
  input  logic                       ctrl_trigger,
  input  logic                       cfg_trig_en,
  input  logic [BURST_CNT_WIDTH-1:0] cfg_num_bursts,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [DATA_W-1:0]          s_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic                       status_busy,
  output logic                       status_done,
  output logic                       status_overflow,
  output logic [BURST_CNT_WIDTH-1:0] status_bursts,
  output logic [OVF_CNT_W-1:0]       status_ovf_count
);

  localparam int                BEAT_W    = $clog2(AXIS_BURST_LENGTH);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(AXIS_BURST_LENGTH - 1);

  cap_state_t                 state_r, state_nx_s;
  logic [BEAT_W-1:0]          beat_cnt_r;
  logic [BURST_CNT_WIDTH-1:0] num_r, bursts_in_r, bursts_r;
  logic                       hold_r, overflow_r, busy_r, done_r;
  logic                       capturing_s, stg_ready_s, out_acc_s, start_acc_s;
  logic                       abort_cap_s, at_boundary_s, load_s, wrap_load_s;
  logic                       final_load_s, finish_s, ovf_ev_s, hold_set_s;

  assign capturing_s   = (state_r == ST_CAPTURE) || (state_r == ST_DRAIN);
  assign s_axis_tready = ~capturing_s | stg_ready_s;
  assign out_acc_s     = m_axis_tvalid & m_axis_tready;
  assign start_acc_s   = (state_r == ST_IDLE) & ctrl_start;
  assign abort_cap_s   = (state_r == ST_CAPTURE) & ctrl_abort;
  assign at_boundary_s = (beat_cnt_r == '0);
  // hold_r: the closing tlast beat is already in the stage, take nothing more
  assign load_s        = capturing_s & s_axis_tvalid & stg_ready_s & ~hold_r
                         & ~(abort_cap_s & at_boundary_s);
  assign wrap_load_s   = load_s & (beat_cnt_r == BEAT_LAST);
  assign final_load_s  = wrap_load_s & (num_r != '0)
                         & (bursts_in_r == num_r - BURST_CNT_WIDTH'(1));
  assign hold_set_s    = final_load_s
                         | (wrap_load_s & ((state_r == ST_DRAIN) | abort_cap_s))
                         | (abort_cap_s & at_boundary_s);
  assign finish_s      = out_acc_s & m_axis_tlast & hold_r;
  assign ovf_ev_s      = capturing_s & s_axis_tvalid & ~s_axis_tready;

  axis_reg_stage #(.DW(DATA_W)) u_stage (
    .clk       (axis_clk),
    .rst       (axis_rst),
    .in_valid  (load_s),
    .in_ready  (stg_ready_s),
    .in_data   (s_axis_tdata),
    .in_last   (beat_cnt_r == BEAT_LAST),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (m_axis_tdata),
    .out_last  (m_axis_tlast)
  );

  // next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ctrl_start) begin
          state_nx_s = cfg_trig_en ? ST_ARMED : ST_CAPTURE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (ctrl_trigger) begin
          state_nx_s = ST_CAPTURE;
        end else if (ctrl_abort) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        // abort on a burst boundary with nothing left to hand off ends at once
        if (finish_s) begin
          state_nx_s = ST_DONE;
        end else if (abort_cap_s && at_boundary_s && stg_ready_s) begin
          state_nx_s = ST_DONE;
        end else if (ctrl_abort) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (finish_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // state register and registered status flags
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      done_r  <= (state_nx_s == ST_DONE);
    end
  end

  // beat/burst counters, closing flag and sticky overflow
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      num_r       <= '0;
      beat_cnt_r  <= '0;
      bursts_in_r <= '0;
      bursts_r    <= '0;
      hold_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (start_acc_s) begin
      num_r       <= cfg_num_bursts;
      beat_cnt_r  <= '0;
      bursts_in_r <= '0;
      bursts_r    <= '0;
      hold_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (load_s) begin
        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
      end
      if (wrap_load_s) begin
        bursts_in_r <= bursts_in_r + BURST_CNT_WIDTH'(1);
      end
      if (out_acc_s && m_axis_tlast) begin
        bursts_r <= bursts_r + BURST_CNT_WIDTH'(1);
      end
      if (hold_set_s) begin
        hold_r <= 1'b1;
      end
      if (ovf_ev_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

`ifdef AD9361_CAPTURE_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_r;

  // saturating dropped-beat counter
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      ovf_cnt_r <= '0;
    end else if (start_acc_s) begin
      ovf_cnt_r <= '0;
    end else if (ovf_ev_s && (ovf_cnt_r != 16'hFFFF)) begin
      ovf_cnt_r <= ovf_cnt_r + 16'd1;
    end
  end

  assign status_ovf_count = ovf_cnt_r;
`else
  assign status_ovf_count = 16'd0;
`endif

  assign status_busy     = busy_r;
  assign status_done     = done_r;
  assign status_overflow = overflow_r;
  assign status_bursts   = bursts_r;

endmodule

// File: tb/tb_ad9361_capture_ctrl.sv
// Randomised self-checking bench for ad9361_capture_ctrl against a beat-count model.
module tb_ad9361_capture_ctrl;

  localparam int L = 4;
`ifdef AD9361_CAPTURE_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_DRAIN = 3, M_DONE = 4;

  logic         axis_clk = 1'b0;
  logic         axis_rst, ctrl_start, ctrl_abort, ctrl_trigger, cfg_trig_en;
  logic [15:0]  cfg_num_bursts;
  logic         s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [127:0] s_axis_tdata, m_axis_tdata;
  logic         status_busy, status_done, status_overflow;
  logic [15:0]  status_bursts, status_ovf_count;

  ad9361_capture_ctrl #(.AXIS_BURST_LENGTH(L), .BURST_CNT_WIDTH(16)) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .ctrl_start(ctrl_start),
    .ctrl_abort(ctrl_abort), .ctrl_trigger(ctrl_trigger), .cfg_trig_en(cfg_trig_en),
    .cfg_num_bursts(cfg_num_bursts), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
    .status_busy(status_busy), .status_done(status_done),
    .status_overflow(status_overflow), .status_bursts(status_bursts),
    .status_ovf_count(status_ovf_count)
  );

  always #5 axis_clk = ~axis_clk;

  int n_checks = 0, n_err = 0;
  bit auto_data = 1'b1;

  // model: totals of beats taken/emitted and a beat limit (-1 = unlimited)
  int           m_mode, m_taken, m_out, m_limit, m_bursts, m_ovfc, m_cycle;
  bit           m_ovf, m_slot_v, m_slot_l;
  logic [127:0] m_slot_d, m_first_d;
  int           m_last_acc, m_done_at;
  int           m_tl[$];

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_taken = 0; m_out = 0; m_limit = -1; m_bursts = 0;
    m_ovfc = 0; m_ovf = 1'b0; m_slot_v = 1'b0; m_slot_l = 1'b0; m_slot_d = '0;
  endtask

  task automatic clr_track();
    m_tl.delete(); m_first_d = '0; m_last_acc = -100; m_done_at = -200;
  endtask

  task automatic model_step();
    bit cap, tr, acc, load;
    int nmode;
    cap   = (m_mode == M_CAP) || (m_mode == M_DRAIN);
    tr    = !cap || !m_slot_v || m_axis_tready;
    acc   = m_slot_v && m_axis_tready;
    nmode = m_mode;
    case (m_mode)
      M_IDLE: if (ctrl_start) begin
        nmode = cfg_trig_en ? M_ARMED : M_CAP;
        m_taken = 0; m_out = 0; m_bursts = 0; m_ovf = 1'b0; m_ovfc = 0;
        m_limit = (cfg_num_bursts == 16'd0) ? -1 : int'(cfg_num_bursts) * L;
      end
      M_ARMED: begin
        if (ctrl_trigger) nmode = M_CAP;
        else if (ctrl_abort) nmode = M_IDLE;
      end
      M_DONE: nmode = M_IDLE;
      default: ;
    endcase
    if (cap) begin
      // an abort rounds the beat limit up to the end of the current burst
      if (m_mode == M_CAP && ctrl_abort) begin
        m_limit = ((m_taken + L - 1) / L) * L;
        nmode = M_DRAIN;
      end
      if (s_axis_tvalid && !tr) begin
        m_ovf = 1'b1;
        if (m_ovfc < 65535) m_ovfc++;
      end
      load = s_axis_tvalid && tr && (m_limit < 0 || m_taken < m_limit);
      if (acc) begin
        if (m_out == 0) m_first_d = m_slot_d;
        m_out++;
        if (m_slot_l) begin m_bursts++; m_tl.push_back(m_out); end
        m_last_acc = m_cycle;
      end
      if (load) begin
        m_slot_v = 1'b1; m_slot_d = s_axis_tdata; m_slot_l = (m_taken % L == L - 1);
        m_taken++;
      end else if (acc) begin
        m_slot_v = 1'b0;
      end
      if (m_limit >= 0 && m_out == m_limit) nmode = M_DONE;
    end
    m_mode = nmode;
    m_cycle++;
  endtask

  task automatic compare();
    bit cap;
    cap = (m_mode == M_CAP) || (m_mode == M_DRAIN);
    if (m_mode == M_DONE) m_done_at = m_cycle;
    chk("busy", status_busy, m_mode != M_IDLE);
    chk("done", status_done, m_mode == M_DONE);
    chk("s_tready", s_axis_tready, !cap || !m_slot_v || m_axis_tready);
    chk("m_tvalid", m_axis_tvalid, m_slot_v);
    if (m_slot_v) begin
      chk("m_tdata", m_axis_tdata, m_slot_d);
      chk("m_tlast", m_axis_tlast, m_slot_l);
    end
    chk("bursts", status_bursts, m_bursts & 16'hFFFF);
    chk("overflow", status_overflow, m_ovf);
    chk("ovf_count", status_ovf_count, OVF_EN ? m_ovfc : 0);
  endtask

  // inputs are already set at the falling edge; check, then advance past the rising edge
  task automatic tick();
    if (auto_data) s_axis_tdata = rnd128();
    #1;
    if (axis_rst) model_reset();
    compare();
    if (!axis_rst) model_step();
    @(negedge axis_clk);
  endtask

  task automatic run_until_idle(input string nm);
    int k;
    k = 0;
    while (m_mode != M_IDLE && k < 200) begin tick(); k++; end
    chk(nm, m_mode == M_IDLE, 1'b1);
  endtask

  task automatic start_cap(input bit trig, input int n);
    clr_track();
    cfg_trig_en = trig; cfg_num_bursts = 16'(n); ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
  endtask

  initial begin
    axis_rst = 1'b1; ctrl_start = 1'b0; ctrl_abort = 1'b0; ctrl_trigger = 1'b0;
    cfg_trig_en = 1'b0; cfg_num_bursts = 16'd0; s_axis_tvalid = 1'b0;
    s_axis_tdata = '0; m_axis_tready = 1'b1; m_cycle = 0;
    model_reset(); clr_track();
    @(negedge axis_clk);
    repeat (3) tick();
    chk("rst_busy", status_busy, 1'b0);
    chk("rst_tready", s_axis_tready, 1'b1);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, 128'd0);
    axis_rst = 1'b0;
    tick();

    // two bursts, continuous flow
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    start_cap(1'b0, 2);
    run_until_idle("r26_idle");
    chk("r26_beats", m_out, 8);
    chk("r26_tl_n", m_tl.size(), 2);
    chk("r26_tl_a", m_tl[0], 4);
    chk("r26_tl_b", m_tl[1], 8);
    chk("r26_done_lat", m_done_at - m_last_acc, 1);
    chk("r26_bursts", status_bursts, 16'd2);

    // armed: beats before the trigger are discarded
    start_cap(1'b1, 1);
    repeat (10) tick();
    chk("r27_dropped", m_taken, 0);
    chk("r27_busy", status_busy, 1'b1);
    ctrl_trigger = 1'b1; tick(); ctrl_trigger = 1'b0;
    auto_data = 1'b0; s_axis_tdata = rnd128();
    begin
      logic [127:0] d1;
      d1 = s_axis_tdata;
      tick();
      auto_data = 1'b1;
      run_until_idle("r27_idle");
      chk("r27_first", m_first_d, d1);
      chk("r27_beats", m_out, 4);
    end

    // continuous capture aborted after beat 6 drains to beat 8
    start_cap(1'b0, 0);
    for (int k = 0; k < 20 && m_taken < 6; k++) tick();
    ctrl_abort = 1'b1; tick(); ctrl_abort = 1'b0;
    run_until_idle("r28_idle");
    chk("r28_beats", m_out, 8);
    chk("r28_tl_b", m_tl[1], 8);
    chk("r28_done_lat", m_done_at - m_last_acc, 1);

    // downstream stall for three cycles right at capture start
    m_axis_tready = 1'b1;
    start_cap(1'b0, 1);
    m_axis_tready = 1'b0;
    repeat (3) tick();
    m_axis_tready = 1'b1;
    run_until_idle("r29_idle");
    chk("r29_ovf", status_overflow, 1'b1);
    chk("r29_ovfcnt", status_ovf_count, OVF_EN ? 16'd2 : 16'd0);
    chk("r29_beats", m_out, 4);

    // reset mid-burst, then a fresh one-burst capture
    start_cap(1'b0, 0);
    for (int k = 0; k < 10 && m_taken < 2; k++) tick();
    axis_rst = 1'b1; tick();
    chk("r30_tvalid", m_axis_tvalid, 1'b0);
    chk("r30_tlast", m_axis_tlast, 1'b0);
    axis_rst = 1'b0; tick();
    start_cap(1'b0, 1);
    run_until_idle("r30_idle");
    chk("r30_tl_n", m_tl.size(), 1);
    chk("r30_tl_a", m_tl[0], 4);

    // random traffic and control
    for (int c = 0; c < 3000; c++) begin
      axis_rst       = ($urandom_range(0, 999) == 0);
      ctrl_start     = ($urandom_range(0, 15) == 0);
      ctrl_abort     = ($urandom_range(0, 23) == 0);
      ctrl_trigger   = ($urandom_range(0, 7) == 0);
      cfg_trig_en    = $urandom_range(0, 1);
      cfg_num_bursts = 16'($urandom_range(0, 3));
      s_axis_tvalid  = ($urandom_range(0, 3) != 0);
      m_axis_tready  = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ad9361_capture_ctrl.md
AD9361_CAPTURE_CTRL -- requirements
Module: ad9361_capture_ctrl

Interface
REQ-001 SHALL have parameter AXIS_BURST_LENGTH, default 512: beats per burst, a power of two, minimum 2.
REQ-002 SHALL have parameter BURST_CNT_WIDTH, default 16: width of the burst-count configuration and status fields.
REQ-003 SHALL use one clock, axis_clk; reset axis_rst is asynchronous and active-high.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- axis_clk, in, 1, sole clock.
- axis_rst, in, 1, async active-high reset.
- ctrl_start, in, 1, start capture (single-cycle pulse).
- ctrl_abort, in, 1, abort capture (single-cycle pulse).
- ctrl_trigger, in, 1, external trigger (pulse).
- cfg_trig_en, in, 1, when 1, wait for ctrl_trigger before capturing.
- cfg_num_bursts, in, BURST_CNT_WIDTH, bursts per capture; 0 means continuous.
- s_axis_tvalid, in, 1, serializer beat valid.
- s_axis_tready, out, 1, ready to serializer.
- s_axis_tdata, in, 128, packed IQ beat.
- m_axis_tvalid, out, 1, DMA-side beat valid.
- m_axis_tready, in, 1, DMA-side ready.
- m_axis_tlast, out, 1, last beat of a burst.
- m_axis_tdata, out, 128, DMA-side data.
- status_busy, out, 1, FSM not in IDLE.
- status_done, out, 1, one-cycle pulse at capture end.
- status_overflow, out, 1, sticky overflow flag.
- status_bursts, out, BURST_CNT_WIDTH, bursts completed in the current capture.
- status_ovf_count, out, 16, saturating count of dropped beats.

Function
REQ-005 SHALL implement FSM states IDLE, ARMED, CAPTURE, DRAIN, DONE.
REQ-006 IDLE: on ctrl_start go to ARMED if cfg_trig_en=1, else to CAPTURE; latch cfg_num_bursts and cfg_trig_en at start; clear status_bursts and status_overflow.
REQ-007 ARMED: ctrl_trigger → CAPTURE; ctrl_abort → IDLE, with no done pulse; a trigger coincident with ctrl_start in IDLE SHALL be ignored.
REQ-008 CAPTURE: each accepted input beat increments a beat counter, log2(AXIS_BURST_LENGTH) bits wide, that wraps to 0 after AXIS_BURST_LENGTH-1.
REQ-009 That wrapping beat is forwarded with m_axis_tlast=1, and status_bursts increments when it is accepted downstream.
REQ-010 When the last beat of burst number latched_num_bursts is accepted, go to DONE; if latched_num_bursts is 0, never self-terminate.
REQ-011 ctrl_abort in CAPTURE → DRAIN; DRAIN keeps capturing until the current burst's tlast beat is accepted downstream, then goes to DONE.
REQ-012 An abort when the beat counter is 0 and the output stage is empty SHALL go directly to DONE, so no partial burst is ever emitted.
REQ-013 DONE SHALL last one cycle, pulse status_done=1, then return to IDLE.
REQ-014 ctrl_start outside IDLE, and ctrl_trigger outside ARMED, SHALL be ignored.
REQ-015 Outside CAPTURE and DRAIN: s_axis_tready=1, input beats are discarded, and m_axis_tvalid=0.
REQ-016 In CAPTURE and DRAIN: s_axis_tready = ~m_axis_tvalid | m_axis_tready; the output stage is a registered single-entry stage; latency from input to m_axis_tvalid is 1 cycle.
REQ-017 m_axis_tdata and m_axis_tlast SHALL hold stable while m_axis_tvalid & ~m_axis_tready.
REQ-018 Overflow: s_axis_tvalid & ~s_axis_tready in CAPTURE or DRAIN sets status_overflow and drops the beat; the beat counter SHALL NOT advance for a dropped beat.
REQ-019 status_busy = (state != IDLE).

Reset
REQ-020 axis_rst SHALL force: state IDLE, all counters 0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, status_* = 0, s_axis_tready=1 after release.
REQ-021 Reset mid-burst SHALL abandon the burst with no tlast emitted; the first capture after reset starts at beat 0.

Configuration
REQ-022 Macro AD9361_CAPTURE_OVF_CNT_EN defined: status_ovf_count increments once per dropped beat, saturates at 0xFFFF, and clears on ctrl_start accepted in IDLE.
REQ-023 Macro undefined: status_ovf_count is tied to 0 and the counter logic is absent; status_overflow is unaffected.

Structure
REQ-024 Package ad9361_capture_pkg SHALL hold the FSM state enumeration, the 128-bit data width constant and the 16-bit overflow-count width constant.
REQ-025 The output register stage SHALL be a sub-module axis_reg_stage (valid/ready/data/last, one entry); FSM and counters remain in ad9361_capture_ctrl.

Verification
REQ-026 AXIS_BURST_LENGTH=4, cfg_num_bursts=2, cfg_trig_en=0, m_axis_tready=1, continuous input → exactly 8 output beats, tlast on beats 4 and 8, status_done pulse one cycle after beat 8, status_bursts=2.
REQ-027 cfg_trig_en=1, start, 10 input beats, then trigger → first 10 beats dropped, the capture begins at the first beat after trigger, status_busy=1 throughout.
REQ-028 cfg_num_bursts=0, abort after input beat 6 (burst length 4) → output stops after beat 8 with tlast, then DONE pulse, then IDLE.
REQ-029 m_axis_tready=0 for 3 cycles with continuous input → m_axis_tdata held stable, status_overflow=1, status_ovf_count=2 (macro defined) or 0 (undefined), beat count excludes dropped beats.
REQ-030 Assert axis_rst at beat 2 of a burst → outputs reset immediately; the next capture emits its first tlast on beat 4.
